// File: rtl/full_subtractor_reg_pkg.sv
// Shared constants and helpers for the registered full subtractor.
// Holds the width limit checked when the top is elaborated.
package full_subtractor_reg_pkg;

  localparam int FS_MAX_WIDTH = 64;

  function automatic bit fs_width_ok(input int w);
    return (w >= 1) && (w <= FS_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/full_subtractor_reg_if.sv
// Operand/result bundle for full_subtractor_reg: the master drives operands, the slave returns results.
// No ready signal: every in_valid yields one out_valid a cycle later.
interface full_subtractor_reg_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output in_valid, a, b, bin,
    input  out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin,
    output out_valid, diff, bout
  );
endinterface

// File: rtl/full_subtractor_reg_fs_bit.sv
// One-bit combinational full subtractor cell; zero latency, no flow control.
module fs_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/full_subtractor_reg.sv
// Registered ripple-borrow subtractor computing a - b - bin; latency 1 cycle.
// No backpressure: each in_valid yields exactly one out_valid; results hold while idle.
module full_subtractor_reg
  import full_subtractor_reg_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  full_subtractor_reg_if.slave io
);

  if (!fs_width_ok(WIDTH)) begin : g_bad_width
    $error("full_subtractor_reg: WIDTH %0d outside 1..%0d", WIDTH, FS_MAX_WIDTH);
  end

  logic [WIDTH-1:0] diff_c;
  logic             bout_c;

  // Borrow threads through per-cell nets so each bit only sees its lower neighbour.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic br_in;
    logic br_out;

    if (i == 0) begin : g_first
      assign br_in = io.bin;
    end else begin : g_rest
      assign br_in = g_bit[i-1].br_out;
    end

    fs_bit u_bit (
      .a    (io.a[i]),
      .b    (io.b[i]),
      .bin  (br_in),
      .diff (diff_c[i]),
      .bout (br_out)
    );
  end

  assign bout_c = g_bit[WIDTH-1].br_out;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] diff_d, diff_q;
  logic             bout_d, bout_q;

  always_comb begin
    out_valid_d = io.in_valid;
    diff_d      = diff_q;
    bout_d      = bout_q;
    if (io.in_valid) begin
      diff_d = diff_c;
      bout_d = bout_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.diff      = diff_q;
  assign io.bout      = bout_q;

endmodule

// File: tb/tb_full_subtractor_reg.sv
// Bench for full_subtractor_reg at WIDTH 1, 8 and 16 with a queue-based scoreboard.
module tb_full_subtractor_reg;

  typedef struct {
    logic        bout;
    logic [15:0] diff;
  } exp_t;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t q1[$];
  exp_t q8[$];
  exp_t q16[$];

  full_subtractor_reg_if #(.WIDTH(1))  if1 ();
  full_subtractor_reg_if #(.WIDTH(8))  if8 ();
  full_subtractor_reg_if #(.WIDTH(16)) if16 ();

  full_subtractor_reg #(.WIDTH(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .io(if1));
  full_subtractor_reg #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .io(if8));
  full_subtractor_reg #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .io(if16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    $display("FAIL %s: out_valid=1 with no pending expectation", name);
  endtask

  // Monitors: pop one expectation whenever a DUT presents a result.
  always @(negedge clk) begin
    if (rst_n && if1.out_valid === 1'b1) begin
      if (q1.size() == 0) unexpected("w1_unexpected");
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("w1_diff", 64'(if1.diff), 64'(e.diff));
        chk("w1_bout", 64'(if1.bout), 64'(e.bout));
      end
    end
    if (rst_n && if8.out_valid === 1'b1) begin
      if (q8.size() == 0) unexpected("w8_unexpected");
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("w8_diff", 64'(if8.diff), 64'(e.diff));
        chk("w8_bout", 64'(if8.bout), 64'(e.bout));
      end
    end
    if (rst_n && if16.out_valid === 1'b1) begin
      if (q16.size() == 0) unexpected("w16_unexpected");
      else begin
        exp_t e;
        e = q16.pop_front();
        chk("w16_diff", 64'(if16.diff), 64'(e.diff));
        chk("w16_bout", 64'(if16.bout), 64'(e.bout));
      end
    end
  end

  task automatic drive1(input logic a, input logic b, input logic bin,
                        input logic e_diff, input logic e_bout);
    exp_t e;
    if1.a = a; if1.b = b; if1.bin = bin; if1.in_valid = 1'b1;
    e.diff = 16'(e_diff); e.bout = e_bout;
    q1.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [7:0] e_diff, input logic e_bout);
    exp_t e;
    if8.a = a; if8.b = b; if8.bin = bin; if8.in_valid = 1'b1;
    e.diff = 16'(e_diff); e.bout = e_bout;
    q8.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic bin,
                         input logic [15:0] e_diff, input logic e_bout);
    exp_t e;
    if16.a = a; if16.b = b; if16.bin = bin; if16.in_valid = 1'b1;
    e.diff = e_diff; e.bout = e_bout;
    q16.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_w1_out"},  64'({if1.out_valid,  if1.bout,  if1.diff}),  64'd0);
    chk({tag, "_w8_out"},  64'({if8.out_valid,  if8.bout,  if8.diff}),  64'd0);
    chk({tag, "_w16_out"}, 64'({if16.out_valid, if16.bout, if16.diff}), 64'd0);
  endtask

  // {diff,bout} for (a,b,bin) = 000..111, worked out by hand.
  logic [1:0] tbl1 [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    if1.in_valid = 1'b1; if1.a = 1'b1; if1.b = 1'b0; if1.bin = 1'b0;
    if8.in_valid = 1'b0;  if8.a = '0;  if8.b = '0;  if8.bin = 1'b0;
    if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.bin = 1'b0;

    #3  chk_zero("rst_before_edge");
    #4  chk_zero("rst_after_edge");
    #10 chk_zero("rst_later");
    if1.in_valid = 1'b0;
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      logic [2:0] p;
      logic [1:0] t;
      p = 3'(i);
      t = tbl1[i];
      drive1(p[2], p[1], p[0], t[1], t[0]);
    end
    // Last vector was 111; idle with zeros must hold diff=1, bout=1.
    if1.in_valid = 1'b0; if1.a = 1'b0; if1.b = 1'b0; if1.bin = 1'b0;
    @(posedge clk); #1;
    chk("hold_out_valid", 64'(if1.out_valid), 64'd0);
    chk("hold_diff",      64'(if1.diff),      64'd1);
    chk("hold_bout",      64'(if1.bout),      64'd1);
    @(posedge clk); #1;
    chk("hold2_diff_bout", 64'({if1.diff, if1.bout}), 64'b11);

    drive8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    drive8(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
    drive8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    drive8(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);
    drive8(8'h05, 8'h05, 1'b0, 8'h00, 1'b0);
    if8.in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset lands while a fresh result is showing; that result is discarded.
    drive8(8'h33, 8'h11, 1'b0, 8'h22, 1'b0);
    if8.in_valid = 1'b0;
    rst_n = 1'b0;
    q8.delete();
    #1 chk_zero("rst_mid");
    #2 rst_n = 1'b1;
    drive8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    if8.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("w8_after_rst_idle_valid", 64'(if8.out_valid), 64'd0);

    drive16(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1);
    drive16(16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
    drive16(16'h1234, 16'h0234, 1'b1, 16'h0FFF, 1'b0);
    for (int i = 0; i < 10000; i++) begin
      logic [15:0] ra, rb;
      logic        rbin;
      logic [16:0] m;
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      m    = {1'b0, ra} - {1'b0, rb} - 17'(rbin);
      drive16(ra, rb, rbin, m[15:0], m[16]);
    end
    if16.in_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("w1_queue_drained",  64'(q1.size()),  64'd0);
    chk("w8_queue_drained",  64'(q8.size()),  64'd0);
    chk("w16_queue_drained", 64'(q16.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/full_subtractor_reg.md
# full_subtractor_reg

Registered full subtractor: computes `a - b - bin` over WIDTH bits and produces the difference and a borrow-out. At the default WIDTH = 1 it is the classic one-bit full subtractor with a one-cycle output register. Wider instances are a ripple-borrow chain of one-bit cells, used as a building block for arithmetic datapaths that need a clean, registered borrow.

## Interface
- `WIDTH`, default 1: operand and difference width in bits; legal range is 1 to 64.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: the operands on this cycle are to be computed.
- `a` input WIDTH: minuend.
- `b` input WIDTH: subtrahend.
- `bin` input 1: borrow-in, weight 2^0.
- `out_valid` output 1: `diff` and `bout` hold a fresh result.
- `diff` output WIDTH: `(a - b - bin) mod 2^WIDTH`.
- `bout` output 1: borrow-out; 1 exactly when `a < b + bin`, compared as unsigned values.

## Operation
- Per-bit cell i, with the borrow chain starting at `br[0] = bin`:
  - `d[i] = a[i] ^ b[i] ^ br[i]`
  - `br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i])`
  - `bout = br[WIDTH]`
- All arithmetic is unsigned. No signed or overflow flag is produced.
- At WIDTH = 1 the truth table, listed as (a,b,bin) -> (diff,bout):
  - 000 -> 00, 001 -> 11, 010 -> 11, 011 -> 01
  - 100 -> 10, 101 -> 00, 110 -> 00, 111 -> 11
- When `in_valid` is 1, the combinational result is captured into the `diff` and `bout` registers.
- When `in_valid` is 0, `diff` and `bout` hold their previous values and `out_valid` falls to 0.
- There is no backpressure. Every valid input produces exactly one valid output.

## Timing
- Latency is exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N, with `out_valid` = 1 for that one cycle.
- Throughput is one operation per cycle. Back-to-back `in_valid` gives back-to-back `out_valid`.
- While `rst_n` is 0, all outputs are forced to 0 immediately, without waiting for a clock edge: `diff` = 0, `bout` = 0, `out_valid` = 0.
- Reset asserted mid-stream discards any pending result. After `rst_n` rises, the first valid input is captured on the next rising edge.
- The borrow chain is purely combinational: WIDTH cells from input ports to the output register. No internal pipelining.

## Structure
- The shared arithmetic package holds the `FS_MAX_WIDTH = 64` constant, used for the parameter range check.
- The one-bit combinational cell is the sub-module `fs_bit`:
  - inputs `a`, `b`, `bin`; outputs `diff`, `bout`
  - instantiated WIDTH times through a generate loop
- The top level contains the generate chain, the output register, and an elaboration-time assertion on `WIDTH`.

## Test plan
- Reset check: hold `rst_n` = 0 with `a` = 1, `b` = 0, `bin` = 0, `in_valid` = 1 → `diff` = 0, `bout` = 0, `out_valid` = 0, including between clock edges.
- Exhaustive WIDTH = 1: apply the eight (a,b,bin) patterns 000 through 111, one per cycle with `in_valid` = 1. One cycle later each must match the truth table above, e.g. 011 → diff 0, bout 1; 100 → diff 1, bout 0.
- Hold behaviour: drive 111 valid, then `in_valid` = 0 with 000 on the inputs → `diff` = 1, `bout` = 1 held, and `out_valid` = 0 on the second cycle.
- WIDTH = 8 wrap: `a` = 0x00, `b` = 0x01, `bin` = 0 → `diff` = 0xFF, `bout` = 1. Then `a` = 0x80, `b` = 0x7F, `bin` = 1 → `diff` = 0x00, `bout` = 0.
- Reset mid-stream: pulse `rst_n` low between two valid inputs → outputs go to 0 asynchronously. The next valid input (0x05 - 0x03 - 0) gives `diff` = 0x02, `bout` = 0 one cycle later.
- Random WIDTH = 16: 10k random operand sets → compare against the reference model `{bout,diff} = {1'b0,a} - {1'b0,b} - bin`, with `bout` taken as bit 16 of that subtraction.
